// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and constants for the intersection phase sequencer.
package traffic_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_NIGHT = 2'd2
  } state_e;

  // Lamp encoding {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [1:0] PH_NS_G = 2'd0;
  localparam logic [1:0] PH_NS_Y = 2'd1;
  localparam logic [1:0] PH_EW_G = 2'd2;
  localparam logic [1:0] PH_EW_Y = 2'd3;

endpackage

// File: rtl/traffic_phase_sequencer_bin_to_bcd2.sv
// Combinational binary to two-digit BCD; tens found by compare-subtract.
module bin_to_bcd2 #(
  parameter int unsigned BITS = 5
) (
  input  logic [BITS-1:0] bin_i,
  output logic [3:0]      tens_c_o,
  output logic [3:0]      ones_c_o
);

  localparam int unsigned W = (BITS > 7) ? BITS : 7;

  logic [W-1:0] val_c;
  logic [W-1:0] rem_c;

  // Largest multiple of ten not exceeding the input wins
  always_comb begin
    val_c    = W'(bin_i);
    rem_c    = val_c;
    tens_c_o = 4'd0;
    for (int unsigned t = 1; t <= 9; t++) begin
      if (val_c >= W'(10 * t)) begin
        tens_c_o = 4'(t);
        rem_c    = val_c - W'(10 * t);
      end
    end
    ones_c_o = 4'(rem_c);
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer: decodes the timer count/carry into lamps,
// walk signals and a BCD display, with night flashing and timer error check.
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int unsigned MOD       = 27,
  parameter int unsigned BITS      = 5,
  parameter int unsigned WARN_LEN  = 3,
  parameter int unsigned BLINK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            night_mode,
  input  logic            hold_req,
  input  logic [BITS-1:0] count_in,
  input  logic [1:0]      carry_in,
  output logic            light_out_time,
  output logic            hold,
  output logic [2:0]      ns_light,
  output logic [2:0]      ew_light,
  output logic            walk_ns,
  output logic            walk_ew,
  output logic [3:0]      sec_tens,
  output logic [3:0]      sec_ones,
  output logic            phase_err
);

  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TOP     = MOD - 1;

  state_e              state_q, state_d;
  logic [BITS-1:0]     cnt_q, cnt_p_q;
  logic [1:0]          car_q, car_p_q;
  logic [BLINK_W-1:0]  blink_q, blink_d;
  logic                flash_q, flash_d;
  logic                lo_q, lo_d, hold_q, hold_d;
  logic [2:0]          ns_q, ns_d, ew_q, ew_d;
  logic                wns_q, wns_d, wew_q, wew_d;
  logic [3:0]          tens_q, tens_d, ones_q, ones_d;
  logic                err_q, err_d;
  logic [3:0]          tens_c, ones_c;
  logic                wrap_c, cnt_bad_c, car_bad_c, chk_en_c, walk_c;

  bin_to_bcd2 #(.BITS(BITS)) u_bcd (
    .bin_i    (cnt_q),
    .tens_c_o (tens_c),
    .ones_c_o (ones_c)
  );

  // Next state; night request overrides every other exit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (!lo_q && (cnt_q != '0)) state_d = ST_RUN;
      ST_RUN:   if (cnt_q == '0) state_d = ST_INIT;
      ST_NIGHT: state_d = ST_INIT;
      default:  state_d = ST_INIT;
    endcase
    if (night_mode) state_d = ST_NIGHT;
  end

  // Outputs for the state being entered, built from the sampled timer values
  always_comb begin
    lo_d    = 1'b0;
    hold_d  = 1'b0;
    ns_d    = LAMP_RED;
    ew_d    = LAMP_RED;
    wns_d   = 1'b0;
    wew_d   = 1'b0;
    tens_d  = 4'd0;
    ones_d  = 4'd0;
    blink_d = '0;
    flash_d = 1'b1;

    wrap_c    = (32'(cnt_p_q) == 1) && (32'(cnt_q) == TOP);
    cnt_bad_c = (32'(cnt_q) > TOP) ||
                ((cnt_q > cnt_p_q) && !wrap_c) ||
                ((cnt_p_q > cnt_q) && ((cnt_p_q - cnt_q) > BITS'(1)));
    car_bad_c = (car_q != car_p_q) && ((car_q != (car_p_q + 2'd1)) || !wrap_c);
    // A repeated sample means the timer is frozen; nothing to judge
    chk_en_c  = (state_q == ST_RUN) && (state_d == ST_RUN) &&
                ({cnt_q, car_q} != {cnt_p_q, car_p_q});
    err_d     = err_q | (chk_en_c & (cnt_bad_c | car_bad_c));
    walk_c    = (32'(cnt_q) <= WARN_LEN) ? cnt_q[0] : 1'b1;

    unique case (state_d)
      ST_INIT: lo_d = (state_q != ST_INIT);
      ST_RUN: begin
        hold_d = hold_req;
        tens_d = tens_c;
        ones_d = ones_c;
        unique case (car_q)
          PH_NS_G: begin ns_d = LAMP_GRN; wew_d = walk_c; end
          PH_NS_Y: ns_d = LAMP_YEL;
          PH_EW_G: begin ew_d = LAMP_GRN; wns_d = walk_c; end
          PH_EW_Y: ew_d = LAMP_YEL;
          default: ns_d = LAMP_RED;
        endcase
      end
      ST_NIGHT: begin
        lo_d = 1'b1;
        if (state_q == ST_NIGHT) begin
          if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
            flash_d = ~flash_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
            flash_d = flash_q;
          end
        end
        ns_d = flash_d ? LAMP_YEL : LAMP_OFF;
        ew_d = flash_d ? LAMP_RED : LAMP_OFF;
      end
      default: lo_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      cnt_p_q <= '0;
      car_q   <= 2'd0;
      car_p_q <= 2'd0;
      blink_q <= '0;
      flash_q <= 1'b1;
      lo_q    <= 1'b1;
      hold_q  <= 1'b0;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      wns_q   <= 1'b0;
      wew_q   <= 1'b0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= count_in;
      cnt_p_q <= cnt_q;
      car_q   <= carry_in;
      car_p_q <= car_q;
      blink_q <= blink_d;
      flash_q <= flash_d;
      lo_q    <= lo_d;
      hold_q  <= hold_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      wns_q   <= wns_d;
      wew_q   <= wew_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
    end
  end

  assign light_out_time = lo_q;
  assign hold           = hold_q;
  assign ns_light       = ns_q;
  assign ew_light       = ew_q;
  assign walk_ns        = wns_q;
  assign walk_ew        = wew_q;
  assign sec_tens       = tens_q;
  assign sec_ones       = ones_q;
  assign phase_err      = err_q;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Consumer end of the intersection timer interface: samples the timer's count value and phase carry, and drives the intersection outputs.
- Drives NS/EW lamps, pedestrian walk signals and a two-digit BCD seconds display.
- Drives the timer's control inputs back: light-out/clear request and hold request.
- Adds night-mode flashing operation and a sticky protocol-error flag for timer sequence violations.

Parameters:
- MOD, 27: timer modulus; a legal count wraps from 1 to MOD-1.
- BITS, 5: width of count_in; requires MOD-1 < 2**BITS and MOD-1 <= 99.
- WARN_LEN, 3: final counts of a phase during which the walk signal flashes.
- BLINK_DIV, 4: cycles per flash half-period in night mode; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- night_mode  in  1  level request for flashing night operation.
- hold_req  in  1  operator freeze request.
- count_in  in  BITS  timer count value.
- carry_in  in  2  timer phase counter.
- light_out_time  out  1  to timer; 1 forces timer count and carry to 0.
- hold  out  1  to timer hold input; freezes the timer.
- ns_light  out  3  {red, yellow, green}, one-hot or all-zero.
- ew_light  out  3  {red, yellow, green}, one-hot or all-zero.
- walk_ns  out  1  pedestrian walk signal, NS crossing.
- walk_ew  out  1  pedestrian walk signal, EW crossing.
- sec_tens  out  4  BCD tens digit of count_in.
- sec_ones  out  4  BCD ones digit of count_in.
- phase_err  out  1  sticky timer-sequence violation flag.

Behaviour:
- All outputs are registered. Reset values: light_out_time=1, hold=0, ns_light=3'b100, ew_light=3'b100, walk_ns=0, walk_ew=0, sec_tens=0, sec_ones=0, phase_err=0.
- Reset asserted mid-operation returns immediately to the reset values above and state INIT.
- Latency: count_in/carry_in sampled at edge N appear on the outputs after edge N+1 (1 cycle).
- FSM states: INIT, RUN, NIGHT.
- INIT:
  - light_out_time=1 for exactly one cycle after entry, then 0.
  - Both lamps red; walk signals 0.
  - -> NIGHT if night_mode=1 (checked first, every state).
  - -> RUN once the sampled count_in != 0 with light_out_time already 0.
- RUN, phase decode from carry_in:
  - 0: NS green, EW red.
  - 1: NS yellow, EW red.
  - 2: NS red, EW green.
  - 3: NS red, EW yellow.
- RUN, walk signals:
  - walk_ew=1 during phase 0; walk_ns=1 during phase 2; both 0 in phases 1 and 3.
  - When count_in <= WARN_LEN, the active walk output equals count_in[0] (flashing).
- RUN, exits:
  - count_in==0 while in RUN -> INIT (timer was cleared externally).
  - night_mode=1 -> NIGHT.
- NIGHT:
  - light_out_time held at 1.
  - Blink counter counts 0..BLINK_DIV-1; a flash bit toggles on each wrap.
  - ns_light = flash ? yellow : off; ew_light = flash ? red : off; walk signals 0.
  - Flash bit is 1 on NIGHT entry.
  - night_mode=0 -> INIT.
- hold = hold_req registered (one-cycle delay), forced to 0 in NIGHT and INIT. When hold=1, the RUN outputs simply track the frozen inputs.
- Display:
  - sec_tens/sec_ones = BCD of the sampled count_in in RUN.
  - 0/0 in INIT and NIGHT.
  - BCD conversion is combinational (tens by compare-subtract), then registered.
- phase_err, checked in RUN only; not checked in the first RUN cycle or when the previous sample equals the current one (hold). Set on any of:
  - count_in > MOD-1.
  - count increases other than 1 -> MOD-1.
  - count decreases by more than 1.
  - carry_in changes other than +1 mod 4, or changes without a 1 -> MOD-1 count wrap.
- phase_err is sticky; cleared only by reset.
- Simultaneous events: night_mode has priority over the count_in==0 exit and over hold_req.

Decomposition:
- Shared package:
  - State enum (INIT, RUN, NIGHT).
  - Lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
  - Phase encodings PH_NS_G=0, PH_NS_Y=1, PH_EW_G=2, PH_EW_Y=3.
- One sub-module: bin_to_bcd2 (BITS-bit binary in -> two BCD digits, combinational).

Test Plan:
- Reset, then count_in=26, carry_in=0 -> light_out_time pulses 1 then 0; after 2 edges ns_light=001, ew_light=100, walk_ew=1, sec_tens=2, sec_ones=6.
- Step count 3,2,1 in phase 0 -> walk_ew sequence 1,0,1 (count_in[0]); then 1 -> 26 with carry 0 -> 1 gives ns_light=010, walk_ew=0, phase_err=0.
- night_mode=1 in RUN with BLINK_DIV=4 -> next cycle light_out_time=1; ns_light toggles 010/000 every 4 cycles, ew_light 100/000, display 0/0. Release -> INIT, then RUN.
- hold_req=1 -> hold=1 one cycle later; inputs frozen at 15 -> no phase_err, display 1/5.
- Illegal jump count 10 -> 20 in RUN -> phase_err=1 and stays 1; carry 1 -> 3 separately also sets it; reset clears it.
- Reset asserted mid-RUN (phase 2) -> outputs return to reset values asynchronously, before the next clock edge.
